dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder. It is the slave end of the pipeline's MEM-stage load/store interface.
- Accepts one word request per valid/ready handshake, inserts a programmable number of wait states, performs the read or write, then returns a response under a valid/ready handshake.
- Replaces the zero-latency data memory so the pipeline can be stalled against realistic memory timing.

Parameters:
- ADDR_W, 7: word-address width; the array holds 2**ADDR_W words.
- WAIT_CYCLES, 2: wait states between request acceptance and response, 0 to 15.
- DATA_W, 32: data width; fixed at 32, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0. The array contents are not cleared.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch we/addr/wdata/be and load the counter with WAIT_CYCLES.
  - Next state is WAIT, or ACCESS if WAIT_CYCLES = 0.
- WAIT:
  - req_ready = 0; the counter decrements once per cycle.
  - Go to ACCESS on the cycle the counter reaches 1.
- ACCESS (one cycle):
  - Error check: err = (addr[1:0] != 0) | (addr[31:ADDR_W+2] != 0).
  - If not err and we: write the array at addr[ADDR_W+1:2] using the latched byte enables.
  - If not err and not we: register the array word into rsp_rdata.
  - Register rsp_err = err. Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready.
  - On that handshake: go to IDLE, then drop rsp_valid and clear rsp_rdata and rsp_err.
- Latency: acceptance edge to rsp_valid high = WAIT_CYCLES + 2 edges.
- Back-to-back throughput: one request per WAIT_CYCLES + 3 cycles when rsp_ready is held at 1.
- req_ready is low from acceptance through the response handshake cycle. A new request is never accepted in the same cycle as a response handshake.
- A store becomes visible to a read of the same word accepted after it; the responder has no internal reordering.
- A store with all req_be = 0 performs no write but still completes normally with rsp_err = 0.
- Reset mid-operation:
  - In WAIT: the store is abandoned and the array is unchanged.
  - In ACCESS: a store already committed on that edge stays committed.
  - rsp_valid drops on the reset edge in every state.
- req_* inputs are sampled only at acceptance; changes while req_ready = 0 are ignored.

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- Defined: req_be is honoured per byte as described above.
- Undefined:
  - req_be is ignored and every error-free store writes the full word.
  - The all-zero-enable case becomes a full-word write.
  - The req_be port remains present but unused.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, ACCESS, RESP}, 2-bit encoding.
  - constant WORD_BYTES = 4.
  - function is_misaligned(addr).
  - function in_range(addr, ADDR_W).
- Sub-module dmem_array: single-port synchronous storage.
  - Inputs: clk, we, be, word address, wdata. Output: registered rdata.
  - Byte-enable write logic is guarded by DMEM_BYTE_WRITE_EN.
- The FSM and counter stay in dmem_responder.

Test Plan:
1. Reset then idle.
   - Stimulus: rst high 2 cycles, then low.
   - Required: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
2. Store then load, WAIT_CYCLES = 2.
   - Stimulus: store addr 0x10, wdata 0xDEADBEEF, be 0xF; then load addr 0x10 with rsp_ready = 1.
   - Required: rsp_valid 4 edges after each acceptance, load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
3. Byte write (macro defined).
   - Stimulus: store addr 0x10, wdata 0x000000AA, be 0x1; then load addr 0x10.
   - Required: rdata = 0xDEADBEAA.
   - With the macro undefined: rdata = 0x000000AA.
4. Errors.
   - Stimulus: load addr 0x12, then store addr 0x200 (ADDR_W = 7).
   - Required: each gives rsp_err = 1 and rsp_rdata = 0; a read of word 0x00 afterwards shows the array unchanged.
5. Response backpressure.
   - Stimulus: hold rsp_ready = 0 for 5 cycles during RESP.
   - Required: rsp_valid, rsp_rdata and rsp_err stable; req_ready = 0 throughout; IDLE one cycle after rsp_ready rises.
6. Reset mid-WAIT and zero-wait.
   - Stimulus: store 0x12345678 to addr 0x20; assert rst in the first WAIT cycle.
   - Required: a read of addr 0x20 returns the prior value.
   - Stimulus: WAIT_CYCLES = 0.
   - Required: rsp_valid 2 edges after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the multi-cycle data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int unsigned WORD_BYTES = 4;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

   // True when every byte-address bit above the word index is zero.
   function automatic logic in_range(input logic [31:0] addr, input int unsigned addr_w);
      return (addr >> (addr_w + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word storage with registered read data.
// Per-byte write enables are honoured only when DMEM_BYTE_WRITE_EN is defined.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
`ifdef DMEM_BYTE_WRITE_EN
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
`else
         mem[addr] <= wdata;
`endif
      end
      // Read-first: a write on this edge is seen by the next read.
      rdata <= mem[addr];
   end

`ifndef DMEM_BYTE_WRITE_EN
   logic unused_be;
   assign unused_be = ^be;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, WAIT_CYCLES wait states,
// one access cycle, then a held valid/ready response. Byte enables: DMEM_BYTE_WRITE_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DATA_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [WORD_BYTES-1:0] req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   state_t                state, state_n;
   logic [3:0]            cnt;
   logic                  we_q;
   logic [31:0]           addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [WORD_BYTES-1:0] be_q;
   logic                  accept;
   logic                  err;
   logic                  arr_we;
   logic [ADDR_W-1:0]     arr_addr;
   logic [DATA_W-1:0]     arr_rdata;

   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_n = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
         end
         WAIT:    if (cnt <= 4'd1) state_n = ACCESS;
         ACCESS:  state_n = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign accept = req_valid && req_ready;
   assign err    = is_misaligned(addr_q) || !in_range(addr_q, ADDR_W);
   assign arr_we = (state == ACCESS) && !err && we_q;

   // The array read is registered, so the request address is presented on the
   // acceptance edge itself; this keeps load data ready for a zero-wait ACCESS.
   assign arr_addr = (state == IDLE) ? req_addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt     <= 4'(WAIT_CYCLES);
         end
         if (state == WAIT) cnt <= cnt - 4'd1;
         if (state == ACCESS) begin
            rsp_err   <= err;
            rsp_rdata <= (!err && !we_q) ? arr_rdata : '0;
         end
         if (state == RESP && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (be_q),
      .addr  (arr_addr),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (WAIT_CYCLES = 2 and a zero-wait instance).
module tb_dmem_responder;

   localparam int unsigned W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        b_req_valid, b_req_ready, b_req_we;
   logic [31:0] b_req_addr, b_req_wdata;
   logic [3:0]  b_req_be;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   int          nchecks = 0;
   int          nfails  = 0;
   logic [32:0] sb [$];
   logic [31:0] model [128];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(7), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.ADDR_W(7), .WAIT_CYCLES(0)) dut_zw (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp)
      else begin
         nfails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic addr_err(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr >= 32'd512);
   endfunction

   // One full transaction on the WAIT_CYCLES=2 instance; hold = cycles of rsp backpressure.
   task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input string tag);
      logic [32:0] exp;
      logic [31:0] held;
      int          lat;
      int          idx;
      idx = int'(addr[8:2]);
      if (addr_err(addr)) exp = {1'b1, 32'h0};
      else if (we) begin
`ifdef DMEM_BYTE_WRITE_EN
         for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
`else
         model[idx] = wdata;
`endif
         exp = {1'b0, 32'h0};
      end else exp = {1'b0, model[idx]};
      sb.push_back(exp);

      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = (hold == 0);
      @(posedge clk); #1;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         req_valid = 1'b1;
         req_we    = 1'($urandom);
         req_addr  = $urandom;
         req_wdata = $urandom;
         req_be    = 4'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
      exp = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, exp[31:0]);
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp[32]));
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, "_hold_rdata"}, rsp_rdata, held);
         chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp[32]));
         chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_post_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_post_rdata"}, rsp_rdata, 32'h0);
   endtask

   task automatic req_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input string tag);
      int lat;
      chk({tag, "_req_ready"}, 32'(b_req_ready), 32'd1);
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = 4'hF;
      b_rsp_ready = 1'b1;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      lat = 0;
      while (b_rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd1);
      chk({tag, "_rdata"}, b_rsp_rdata, exp_rdata);
      chk({tag, "_err"}, 32'(b_rsp_err), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_post_valid"}, 32'(b_rsp_valid), 32'd0);
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
      b_rsp_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      req_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10");
      req_a(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, "st_byte");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld_byte");
`ifdef DMEM_BYTE_WRITE_EN
      chk("byte_merge", model[4], 32'hDEADBEAA);
`else
      chk("byte_merge", model[4], 32'h000000AA);
`endif
      req_a(1'b1, 32'h10, 32'h55555555, 4'h0, 0, "st_be0");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld_be0");

      req_a(1'b1, 32'h0, 32'h11223344, 4'hF, 0, "st0");
      req_a(1'b0, 32'h12, 32'h0, 4'h0, 0, "ld_misaligned");
      req_a(1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, 0, "st_range");
      req_a(1'b0, 32'h0, 32'h0, 4'h0, 0, "ld0_after_err");

      req_a(1'b0, 32'h10, 32'h0, 4'h0, 5, "backpressure");

      // Store abandoned by reset in its first WAIT cycle.
      req_a(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, "st20");
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("wait_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("wait_rst_req_ready", 32'(req_ready), 32'd1);
      chk("wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      req_a(1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20_after_rst");

      // Reset while a response is pending.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      guard = 0;
      while (rsp_valid !== 1'b1 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("resp_pending_valid", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      chk("resp_rst_valid", 32'(rsp_valid), 32'd0);
      chk("resp_rst_rdata", rsp_rdata, 32'h0);
      chk("resp_rst_req_ready", 32'(req_ready), 32'd1);

      req_b(1'b1, 32'h4, 32'hA5A5A5A5, 32'h0, "zw_st");
      req_b(1'b0, 32'h4, 32'h0, 32'hA5A5A5A5, "zw_ld");

      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
